// File: rtl/div_share_arb.sv
// div_share_arb
// Shares one fixed-latency pipelined divider between NUM_REQ requesters.
// Round-robin grant, one issue per clock, registered operands, and a tag
// pipeline matched to the divider latency that routes each result back to
// its requester in grant order.
// Optional build macro: DIV_SHARE_ARB_ZERO_GUARD_EN -- when defined, a
// divide-by-zero is tagged at issue and its response is forced to
// quotient = all ones, remainder = 0, ignoring the divider output.
module div_share_arb #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_numer,
    input  logic [NUM_REQ*WIDTH-1:0]     req_denom,
    output logic [WIDTH-1:0]             div_numer,
    output logic [WIDTH-1:0]             div_denom,
    input  logic [WIDTH-1:0]             div_quotient,
    input  logic [WIDTH-1:0]             div_remain,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [WIDTH-1:0]             rsp_quotient,
    output logic [WIDTH-1:0]             rsp_remain,
    output logic [$clog2(LATENCY+3)-1:0] in_flight,
    output logic                         busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY + 3);
    localparam int DEPTH = LATENCY + 1;
    localparam int unsigned NR = NUM_REQ;

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       grant_id;
    logic                  grant_ok;
    logic                  hs;
    int unsigned           scan_idx;
    logic [WIDTH-1:0]      sel_numer;
    logic [WIDTH-1:0]      sel_denom;

    logic [DEPTH-1:0]      tag_vld;
    logic [DEPTH*ID_W-1:0] tag_id;
    logic                  tail_vld;
    logic [ID_W-1:0]       tail_id;
    logic [NUM_REQ-1:0]    tail_onehot;
    logic [WIDTH-1:0]      ret_quotient;
    logic [WIDTH-1:0]      ret_remain;

`ifdef DIV_SHARE_ARB_ZERO_GUARD_EN
    logic [DEPTH-1:0]      tag_zero;
    logic                  tail_zero;
`endif

    // Round-robin scan: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_ok = 1'b0;
        grant_id = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            scan_idx = (32'(rr_ptr) + k) % NR;
            if (!grant_ok && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_ok = 1'b1;
                grant_id = scan_idx[ID_W-1:0];
            end
        end
        if (rst || flush) begin
            grant_ok = 1'b0;
        end
    end

    // One-hot ready; the granted requester is valid by construction.
    always_comb begin
        req_ready = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            req_ready[k] = grant_ok && (grant_id == ID_W'(k));
        end
    end

    assign hs = grant_ok;

    // Operand slice of the granted requester.
    always_comb begin
        sel_numer = '0;
        sel_denom = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_numer = req_numer[k*WIDTH +: WIDTH];
                sel_denom = req_denom[k*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin pointer: advance past the winner, restart at 0 on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
        end else if (hs) begin
            if (grant_id == ID_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_id + 1'b1;
            end
        end
    end

    // Operand registers feeding the divider; hold between grants, survive flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_numer <= '0;
            div_denom <= '0;
        end else if (hs) begin
            div_numer <= sel_numer;
            div_denom <= sel_denom;
        end
    end

    // Tag pipeline, LATENCY+1 deep, so the tail lines up with the divider output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            if (flush) begin
                tag_vld <= '0;
            end else begin
                tag_vld <= {tag_vld[DEPTH-2:0], hs};
            end
            tag_id <= {tag_id[(DEPTH-1)*ID_W-1:0], grant_id};
        end
    end

`ifdef DIV_SHARE_ARB_ZERO_GUARD_EN
    // Divide-by-zero marker travelling alongside the tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_zero <= '0;
        end else begin
            tag_zero <= {tag_zero[DEPTH-2:0], (sel_denom == '0)};
        end
    end

    assign tail_zero = tag_zero[DEPTH-1];
`endif

    assign tail_vld = tag_vld[DEPTH-1];
    assign tail_id  = tag_id[(DEPTH-1)*ID_W +: ID_W];

    // Result selection and one-hot owner decode for the tail entry.
    always_comb begin
        ret_quotient = div_quotient;
        ret_remain   = div_remain;
`ifdef DIV_SHARE_ARB_ZERO_GUARD_EN
        if (tail_zero) begin
            ret_quotient = '1;
            ret_remain   = '0;
        end
`endif
        tail_onehot = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            tail_onehot[k] = (tail_id == ID_W'(k));
        end
    end

    // Response register: one strobe per emerging tag, suppressed by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid    <= '0;
            rsp_quotient <= '0;
            rsp_remain   <= '0;
        end else begin
            rsp_valid <= '0;
            if (tail_vld && !flush) begin
                rsp_valid    <= tail_onehot;
                rsp_quotient <= ret_quotient;
                rsp_remain   <= ret_remain;
            end
        end
    end

    // Outstanding count; an op stays counted through the cycle its strobe is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else if (flush) begin
            in_flight <= '0;
        end else begin
            in_flight <= in_flight + CNT_W'(hs) - CNT_W'(|rsp_valid);
        end
    end

    assign busy = (in_flight != '0);

endmodule

// File: tb/tb_div_share_arb.sv
// tb_div_share_arb
// Self-checking bench for div_share_arb with a behavioural divider and a
// queue-based reference of expected responses (build with or without
// DIV_SHARE_ARB_ZERO_GUARD_EN).
module tb_div_share_arb;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 32;
    localparam int LATENCY = 32;
    localparam int CNT_W   = $clog2(LATENCY + 3);

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_numer;
    logic [NUM_REQ*WIDTH-1:0] req_denom;
    logic [WIDTH-1:0]         div_numer;
    logic [WIDTH-1:0]         div_denom;
    logic [WIDTH-1:0]         div_quotient;
    logic [WIDTH-1:0]         div_remain;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_quotient;
    logic [WIDTH-1:0]         rsp_remain;
    logic [CNT_W-1:0]         in_flight;
    logic                     busy;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;

    div_share_arb #(
        .NUM_REQ(NUM_REQ),
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_numer   (req_numer),
        .req_denom   (req_denom),
        .div_numer   (div_numer),
        .div_denom   (div_denom),
        .div_quotient(div_quotient),
        .div_remain  (div_remain),
        .rsp_valid   (rsp_valid),
        .rsp_quotient(rsp_quotient),
        .rsp_remain  (rsp_remain),
        .in_flight   (in_flight),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Raw divider IP behaviour; for a zero divisor it returns a fixed marker.
    function automatic logic [63:0] div_ip(input logic [31:0] n, input logic [31:0] d);
        if (d == 0) return {32'h0BAD_0BAD, n};
        return {n / d, n % d};
    endfunction

    // Expected response for a request.
    function automatic logic [63:0] expect_div(input logic [31:0] n, input logic [31:0] d);
        if (d == 0) begin
`ifdef DIV_SHARE_ARB_ZERO_GUARD_EN
            return {32'hFFFF_FFFF, 32'h0};
`else
            return {32'h0BAD_0BAD, n};
`endif
        end
        return {n / d, n % d};
    endfunction

    // Behavioural divider: result appears LATENCY clocks after its operands.
    logic [63:0] dpipe [LATENCY];
    always @(posedge clk) begin
        for (int i = LATENCY - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
        dpipe[0] <= div_ip(div_numer, div_denom);
    end
    assign div_quotient = dpipe[LATENCY-1][63:32];
    assign div_remain   = dpipe[LATENCY-1][31:0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state.
    typedef struct {
        int unsigned due;
        int          id;
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t        pend[$];
    int          m_rr = 0;
    logic [31:0] m_q  = 0;
    logic [31:0] m_r  = 0;
    logic [31:0] m_dn = 0;
    logic [31:0] m_dd = 0;

    always @(negedge clk) begin : mon
        logic [NUM_REQ-1:0] e_ready;
        logic [NUM_REQ-1:0] e_rsp;
        logic [63:0]        qr;
        logic [31:0]        n;
        logic [31:0]        d;
        exp_t               e;
        int                 g;
        int                 c;

        if (rst) begin
            pend.delete();
            m_rr = 0; m_q = 0; m_r = 0; m_dn = 0; m_dd = 0;
        end
        while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());

        e_rsp = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e_rsp[pend[0].id] = 1'b1;
            m_q = pend[0].q;
            m_r = pend[0].r;
        end

        g = -1;
        e_ready = '0;
        if (!rst && !flush) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                c = (m_rr + k) % NUM_REQ;
                if (g < 0 && req_valid[c]) g = c;
            end
            if (g >= 0) e_ready[g] = 1'b1;
        end

        check("req_ready", req_ready, e_ready);
        check("rsp_valid", rsp_valid, e_rsp);
        check("rsp_quotient", rsp_quotient, m_q);
        check("rsp_remain", rsp_remain, m_r);
        check("in_flight", in_flight, pend.size());
        check("busy", busy, pend.size() != 0);
        check("div_numer", div_numer, m_dn);
        check("div_denom", div_denom, m_dd);

        if (g >= 0) begin
            n = req_numer[g*WIDTH +: WIDTH];
            d = req_denom[g*WIDTH +: WIDTH];
            qr = expect_div(n, d);
            e.due = cyc + LATENCY + 2;
            e.id  = g;
            e.q   = qr[63:32];
            e.r   = qr[31:0];
            pend.push_back(e);
            m_dn = n;
            m_dd = d;
            m_rr = (g + 1) % NUM_REQ;
        end
        if (flush && !rst) begin
            pend.delete();
            m_rr = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] n, input logic [31:0] d);
        req_numer[i*WIDTH +: WIDTH] = n;
        req_denom[i*WIDTH +: WIDTH] = d;
    endtask

    initial begin : stim
        int peak;
        rst = 1'b1;
        flush = 1'b0;
        req_valid = '0;
        req_numer = '0;
        req_denom = '0;
        repeat (3) tick();
        check("reset_in_flight", in_flight, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Single request on requester 0.
        set_op(0, 1620000, 45);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        repeat (40) tick();

        // Idle flush returns the pointer to 0, then alternating grants.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_op(0, 1000, 9);
        set_op(1, 100, 7);
        req_valid = 2'b11;
        repeat (6) tick();
        req_valid = '0;
        repeat (40) tick();

        // Back-to-back stream on requester 1.
        peak = 0;
        req_valid = 2'b10;
        for (int i = 0; i < 40; i++) begin
            set_op(1, i * 1000, 3);
            tick();
            if (int'(in_flight) > peak) peak = int'(in_flight);
        end
        req_valid = '0;
        repeat (40) begin
            tick();
            if (int'(in_flight) > peak) peak = int'(in_flight);
        end
        check("peak_in_flight", peak, 34);

        // Flush with ops in flight; requests held during flush are not accepted.
        req_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            set_op(0, 7000 + k * 13, 7);
            tick();
        end
        flush = 1'b1;
        req_valid = 2'b11;
        tick();
        flush = 1'b0;
        req_valid = '0;
        check("flush_in_flight", in_flight, 0);
        repeat (40) tick();
        set_op(1, 123456, 10);
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        repeat (40) tick();

        // Randomized traffic with occasional zero divisors and flushes.
        for (int i = 0; i < 300; i++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                set_op(r, $urandom, ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom_range(1, 32'hFFFF));
            end
            req_valid = NUM_REQ'($urandom);
            flush = ($urandom_range(0, 40) == 0);
            tick();
        end
        flush = 1'b0;
        req_valid = '0;
        repeat (40) tick();

        // Asynchronous reset with ops in flight.
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            set_op(0, $urandom, $urandom_range(1, 1000));
            set_op(1, $urandom, $urandom_range(1, 1000));
            tick();
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        req_valid = '0;
        #1;
        check("arst_req_ready", req_ready, 0);
        check("arst_div_numer", div_numer, 0);
        check("arst_div_denom", div_denom, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_quotient", rsp_quotient, 0);
        check("arst_rsp_remain", rsp_remain, 0);
        check("arst_in_flight", in_flight, 0);
        check("arst_busy", busy, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (40) tick();

        // Divide by zero.
        set_op(0, 5, 0);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
